clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_pkg.sv | 5 +
 rtl/clk_gate_ctrl.sv | 68 ++++++
 tb/tb_clk_gate_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared FSM state type and statistics width for clk_gate_ctrl
package clk_gate_pkg;
  typedef enum logic [1:0] {RUN, IDLE_WAIT, GATED, WAKE} clk_gate_state_e;
  localparam int GATE_CNT_W = 32;
endpackage

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-driven clock-gate enable with wake handshake; GATE_STATS_EN adds a saturating gate counter
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic test_en_i,
  input  logic sw_en_i,
  input  logic busy_i,
  input  logic wake_req_i,
  output logic wake_ack_o,
  output logic clk_en_o,
  output logic gated_o
`ifdef GATE_STATS_EN
  ,
  input  logic                  gate_cnt_clr_i,
  output logic [GATE_CNT_W-1:0] gate_cnt_o
`endif
);
  localparam int CNT_WIDTH = $clog2((IDLE_CYCLES > WAKE_CYCLES ? IDLE_CYCLES : WAKE_CYCLES) + 1);
  clk_gate_state_e state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic acked, wake, ack_set;
  assign wake = busy_i | wake_req_i | ~sw_en_i;
  assign ack_set = (state == RUN) & wake_req_i & ~acked & ~wake_ack_o & ~test_en_i;
  // state, shared counter and handshake registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state      <= RUN;
      cnt        <= '0;
      wake_ack_o <= 1'b0;
      acked      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wake_ack_o <= ack_set;
      acked      <= ack_set | (acked & wake_req_i);
    end
  // next state; counter runs only while staying in IDLE_WAIT or WAKE
  always_comb begin
    state_nxt = state;
    if (test_en_i) state_nxt = RUN;
    else
      case (state)
        RUN:       if (sw_en_i & ~busy_i & ~wake_req_i) state_nxt = IDLE_WAIT;
        IDLE_WAIT: state_nxt = wake ? RUN : (cnt == CNT_WIDTH'(IDLE_CYCLES - 1)) ? GATED : IDLE_WAIT;
        GATED:     if (wake) state_nxt = WAKE;
        WAKE:      if (cnt == CNT_WIDTH'(WAKE_CYCLES - 1)) state_nxt = RUN;
        default:   state_nxt = RUN;
      endcase
    cnt_nxt = (state_nxt == state && (state == IDLE_WAIT || state == WAKE)) ? cnt + 1'b1 : '0;
  end
  // outputs decoded from registered state, test mode forces the clock on
  always_comb begin
    clk_en_o = (state != GATED) | test_en_i;
    gated_o  = (state == GATED) & ~test_en_i;
  end
`ifdef GATE_STATS_EN
  // saturating count of gating events, clear wins over increment
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) gate_cnt_o <= '0;
    else if (gate_cnt_clr_i) gate_cnt_o <= '0;
    else if (state == IDLE_WAIT && state_nxt == GATED && gate_cnt_o != '1) gate_cnt_o <= gate_cnt_o + 1'b1;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed and random checks of clk_gate_ctrl against a behavioural model
module tb_clk_gate_ctrl;
  localparam int IDLE_N = 4;
  localparam int WAKE_N = 2;
  logic clk = 0, rst_n = 0, test_en = 0, sw_en = 0, busy = 1, wake_req = 0;
  logic wake_ack, clk_en, gated;
  int n_chk = 0, n_err = 0;
  int waited = -1, wake_rem = 0, gates = 0;
  bit is_gated = 0, hs_done = 0, m_ack = 0;
`ifdef GATE_STATS_EN
  logic gate_cnt_clr = 0;
  logic [31:0] gate_cnt;
`endif
  always #5 clk = ~clk;
  clk_gate_ctrl #(.IDLE_CYCLES(IDLE_N), .WAKE_CYCLES(WAKE_N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .sw_en_i(sw_en), .busy_i(busy),
    .wake_req_i(wake_req), .wake_ack_o(wake_ack), .clk_en_o(clk_en), .gated_o(gated)
`ifdef GATE_STATS_EN
    , .gate_cnt_clr_i(gate_cnt_clr), .gate_cnt_o(gate_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    waited = -1; wake_rem = 0; gates = 0; is_gated = 0; hs_done = 0; m_ack = 0;
  endtask
  task automatic model_step();
    bit running = !is_gated && wake_rem == 0 && waited < 0;
    bit go = busy || wake_req || !sw_en;
    bit nack = running && wake_req && !hs_done && !m_ack && !test_en;
    bit gev = 0;
    hs_done = nack || (wake_req && hs_done);
    m_ack = nack;
    if (test_en) begin
      is_gated = 0; wake_rem = 0; waited = -1;
    end else if (wake_rem > 0) wake_rem--;
    else if (is_gated) begin
      if (go) begin is_gated = 0; wake_rem = WAKE_N; end
    end else if (waited >= 0) begin
      if (go) waited = -1;
      else begin
        waited++;
        if (waited == IDLE_N) begin is_gated = 1; waited = -1; gev = 1; end
      end
    end else if (sw_en && !busy && !wake_req) waited = 0;
`ifdef GATE_STATS_EN
    if (gate_cnt_clr) gates = 0;
    else if (gev) gates++;
`endif
  endtask
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ":clk_en"}, clk_en, !is_gated || test_en);
    chk({tag, ":gated"}, gated, is_gated && !test_en);
    chk({tag, ":ack"}, wake_ack, m_ack);
`ifdef GATE_STATS_EN
    chk({tag, ":gate_cnt"}, gate_cnt, gates);
`endif
  endtask
  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1;
    chk({tag, ":rst_clk_en"}, clk_en, 1);
    chk({tag, ":rst_gated"}, gated, 0);
    chk({tag, ":rst_ack"}, wake_ack, 0);
    model_reset();
    rst_n = 1;
  endtask
  initial begin
    #12;
    chk("reset:clk_en", clk_en, 1);
    chk("reset:gated", gated, 0);
    chk("reset:ack", wake_ack, 0);
    rst_n = 1;
    sw_en = 1; busy = 0;
    for (int i = 0; i < IDLE_N; i++) tick("gate");
    chk("gate:pre_edge4", clk_en, 1);
    tick("gate");
    chk("gate:edge4_en", clk_en, 0);
    chk("gate:edge4_gated", gated, 1);
    wake_req = 1;
    tick("wake_k");
    chk("wake:en_after_k", clk_en, 1);
    tick("wake_k1");
    tick("wake_k2");
    chk("wake:no_ack_k2", wake_ack, 0);
    tick("wake_k3");
    chk("wake:ack_k3", wake_ack, 1);
    tick("wake_k4");
    chk("wake:single_ack", wake_ack, 0);
    tick("wake_hold");
    wake_req = 0;
    tick("wake_rel");
    tick("intr_e1");
    busy = 1;
    tick("intr_e2");
    busy = 0;
    for (int i = 0; i < IDLE_N; i++) tick("intr");
    chk("intr:still_on", clk_en, 1);
    tick("intr_gate");
    chk("intr:gated", clk_en, 0);
    test_en = 1;
    #1;
    chk("test:comb_en", clk_en, 1);
    chk("test:comb_gated", gated, 0);
    wake_req = 1;
    tick("test_e1");
    tick("test_e2");
    chk("test:no_ack", wake_ack, 0);
    tick("test_e3");
    test_en = 0;
    tick("test_drop");
    chk("test:ack_after_drop", wake_ack, 1);
    wake_req = 0;
    for (int i = 0; i < IDLE_N + 1; i++) tick("rg");
    chk("rg:gated", gated, 1);
    async_reset("rg");
`ifdef GATE_STATS_EN
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < IDLE_N + 1; i++) tick("st_idle");
      busy = 1;
      for (int i = 0; i < WAKE_N + 1; i++) tick("st_wake");
      busy = 0;
    end
    chk("stats:three", gate_cnt, 3);
    for (int i = 0; i < IDLE_N; i++) tick("st_clr");
    gate_cnt_clr = 1;
    tick("st_clr_edge");
    chk("stats:clr_wins", gate_cnt, 0);
    gate_cnt_clr = 0;
`endif
    for (int i = 0; i < 800; i++) begin
      sw_en = $urandom_range(0, 15) != 0;
      busy = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 9) == 0) wake_req = ~wake_req;
      test_en = $urandom_range(0, 31) == 0;
`ifdef GATE_STATS_EN
      gate_cnt_clr = $urandom_range(0, 63) == 0;
`endif
      tick("rnd");
      if ($urandom_range(0, 199) == 0) async_reset("rnd");
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
